// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - multi-channel prescaled timer peripheral with W1C pending and priority IRQ ID
module timer_bank #(
  parameter int          NUM_CH    = 4,
  parameter int          WIDTH     = 32,
  parameter int          PRE_WIDTH = 16,
  parameter logic [31:0] BASE_ADDR = 32'h40000100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irqout,
  output logic [3:0]  irq_id,
  input  logic        PC31
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic       hit;
  logic [3:0] ch;
  logic [1:0] rsel;
  logic       unused_bits;

  assign hit         = (addr[31:8] == BASE_ADDR[31:8]);
  assign ch          = addr[7:4];
  assign rsel        = addr[3:2];
  assign unused_bits = &{1'b0, addr[1:0], wdata};

  logic [WIDTH-1:0]     th   [NUM_CH];
  logic [WIDTH-1:0]     tl   [NUM_CH];
  logic [PRE_WIDTH-1:0] pre  [NUM_CH];
  logic [PRE_WIDTH-1:0] pcnt [NUM_CH];
  logic [NUM_CH-1:0]    en, ie, pend, oneshot;
  logic [NUM_CH-1:0]    w_th, w_tl, w_tcon, w_pre, tick, ovf, pi;

  always_comb begin
    w_th   = '0;
    w_tl   = '0;
    w_tcon = '0;
    w_pre  = '0;
    tick   = '0;
    ovf    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr && hit && ch == 4'(c)) begin
        w_th[c]   = (rsel == 2'd0);
        w_tl[c]   = (rsel == 2'd1);
        w_tcon[c] = (rsel == 2'd2);
        w_pre[c]  = (rsel == 2'd3);
      end
      tick[c] = en[c] && (pcnt[c] == pre[c]);
      // A bus write to TL on the same edge suppresses the wrap entirely.
      ovf[c]  = tick[c] && (tl[c] == ALL_ONES) && !w_tl[c];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en      <= '0;
      ie      <= '0;
      pend    <= '0;
      oneshot <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        th[c]   <= '0;
        tl[c]   <= '0;
        pre[c]  <= '0;
        pcnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_th[c])  th[c]  <= wdata[WIDTH-1:0];
        if (w_pre[c]) pre[c] <= wdata[PRE_WIDTH-1:0];

        if (w_tcon[c] || w_pre[c] || tick[c]) pcnt[c] <= '0;
        else if (en[c])                       pcnt[c] <= pcnt[c] + PRE_WIDTH'(1);

        if (w_tl[c])      tl[c] <= wdata[WIDTH-1:0];
        else if (ovf[c])  tl[c] <= th[c];
        else if (tick[c]) tl[c] <= tl[c] + WIDTH'(1);

        // Overflow is OR-ed in after the W1C so a same-edge event is never lost.
        if (w_tcon[c]) begin
          en[c]      <= wdata[0];
          ie[c]      <= wdata[1];
          oneshot[c] <= wdata[3];
          pend[c]    <= (pend[c] & ~wdata[2]) | ovf[c];
        end else begin
          pend[c] <= pend[c] | ovf[c];
          if (ovf[c] && oneshot[c]) en[c] <= 1'b0;
        end
      end
    end
  end

  assign pi     = pend & ie;
  assign irqout = (|pi) & ~PC31;

  always_comb begin
    irq_id = 4'hF;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (pi[c]) irq_id = 4'(c);
    end
  end

  always_comb begin
    rdata = '0;
    if (rd && hit) begin
      if (addr[7:2] == 6'h3C) begin
        rdata = 32'(pi);
      end else if (addr[7:2] == 6'h3D) begin
        rdata = {28'd0, irq_id};
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch == 4'(c)) begin
            case (rsel)
              2'd0:    rdata = 32'(th[c]);
              2'd1:    rdata = 32'(tl[c]);
              2'd2:    rdata = {28'd0, oneshot[c], pend[c], ie[c], en[c]};
              default: rdata = 32'(pre[c]);
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_bank.sv
// tb/tb_timer_bank.sv - self-checking bench for timer_bank with a cycle-level reference model
module tb_timer_bank;

  localparam logic [31:0] BASE = 32'h40000100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic        PC31 = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irqout;
  logic [3:0]  irq_id;

  int n_cmp = 0;
  int n_bad = 0;

  always #10 clk = ~clk;

  timer_bank dut (
    .clk    (clk),
    .reset  (reset),
    .rd     (rd),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .irqout (irqout),
    .irq_id (irq_id),
    .PC31   (PC31)
  );

  // Reference model: architectural state of four 32-bit channels.
  logic [31:0] m_th [4];
  logic [31:0] m_tl [4];
  logic [15:0] m_pre [4];
  logic [15:0] m_pc [4];
  logic        m_en [4];
  logic        m_ie [4];
  logic        m_pend [4];
  logic        m_os [4];

  task automatic m_reset();
    for (int c = 0; c < 4; c++) begin
      m_th[c] = 0; m_tl[c] = 0; m_pre[c] = 0; m_pc[c] = 0;
      m_en[c] = 0; m_ie[c] = 0; m_pend[c] = 0; m_os[c] = 0;
    end
  endtask

  task automatic m_edge(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic sel, wth, wtl, wtc, wpr, tk, ov;
    for (int c = 0; c < 4; c++) begin
      sel = w && (a[31:8] == BASE[31:8]) && (int'(a[7:4]) == c);
      wth = sel && a[3:2] == 2'd0;
      wtl = sel && a[3:2] == 2'd1;
      wtc = sel && a[3:2] == 2'd2;
      wpr = sel && a[3:2] == 2'd3;
      tk  = m_en[c] && (m_pc[c] == m_pre[c]);
      ov  = tk && !wtl && (m_tl[c] == 32'hFFFF_FFFF);
      if (wtl) m_tl[c] = d;
      else if (ov) m_tl[c] = m_th[c];
      else if (tk) m_tl[c] = m_tl[c] + 1;
      if (wtc || wpr || tk) m_pc[c] = 0;
      else if (m_en[c]) m_pc[c] = m_pc[c] + 1;
      if (wtc) begin
        m_pend[c] = (m_pend[c] && !d[2]) || ov;
        m_en[c] = d[0]; m_ie[c] = d[1]; m_os[c] = d[3];
      end else begin
        if (ov && m_os[c]) m_en[c] = 0;
        m_pend[c] = m_pend[c] || ov;
      end
      if (wth) m_th[c] = d;
      if (wpr) m_pre[c] = d[15:0];
    end
  endtask

  function automatic logic [3:0] m_status();
    logic [3:0] s;
    for (int c = 0; c < 4; c++) s[c] = m_pend[c] & m_ie[c];
    return s;
  endfunction

  function automatic logic [3:0] m_id();
    logic [3:0] s;
    s = m_status();
    for (int c = 0; c < 4; c++) if (s[c]) return 4'(c);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int c;
    if (a[31:8] != BASE[31:8]) return 0;
    if (a[7:2] == 6'h3C) return {28'd0, m_status()};
    if (a[7:2] == 6'h3D) return {28'd0, m_id()};
    c = int'(a[7:4]);
    if (c >= 4) return 0;
    case (a[3:2])
      2'd0:    return m_th[c];
      2'd1:    return m_tl[c];
      2'd2:    return {28'd0, m_os[c], m_pend[c], m_ie[c], m_en[c]};
      default: return {16'd0, m_pre[c]};
    endcase
  endfunction

  task automatic tick_cycle(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wr = w; addr = a; wdata = d; rd = 1'b0;
    m_edge(w, a, d);
    @(posedge clk);
    #1;
    wr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick_cycle(1'b0, 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] reg_addr(input int c, input int r);
    return BASE + 32'(c * 16 + r * 4);
  endfunction

  task automatic wreg(input int c, input int r, input logic [31:0] d);
    tick_cycle(1'b1, reg_addr(c, r), d);
  endtask

  task automatic rreg(input logic [31:0] a, output logic [31:0] v);
    rd = 1'b1; addr = a;
    #1;
    v = rdata;
    rd = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; PC31 = 1'b0;
    m_reset();
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      for (int r = 0; r < 4; r++) begin
        rreg(reg_addr(c, r), v);
        n_cmp++;
        if (v !== 32'd0) begin
          n_bad++; $display("FAIL reset_reg ch%0d r%0d got %h exp 0", c, r, v);
        end
      end
    end
    rreg(BASE + 32'hF0, v);
    n_cmp++;
    if (v !== 32'd0) begin n_bad++; $display("FAIL reset_status got %h exp 0", v); end
    rreg(BASE + 32'hF4, v);
    n_cmp++;
    if (v !== 32'hF) begin n_bad++; $display("FAIL reset_id_reg got %h exp f", v); end
    n_cmp++;
    if (irqout !== 1'b0 || irq_id !== 4'hF) begin
      n_bad++; $display("FAIL reset_irq got %b/%h exp 0/f", irqout, irq_id);
    end
  endtask

  task automatic test_periodic();
    logic [31:0] v, t;
    do_reset();
    wreg(0, 0, 32'hFFFF_FFFC);
    wreg(0, 1, 32'hFFFF_FFFC);
    wreg(0, 3, 32'd0);
    wreg(0, 2, 32'd3);
    for (int i = 1; i <= 4; i++) begin
      idle(1);
      rreg(reg_addr(0, 1), t);
      rreg(reg_addr(0, 2), v);
      n_cmp++;
      if (t !== ((i < 4) ? 32'hFFFF_FFFC + 32'(i) : 32'hFFFF_FFFC) || v !== ((i < 4) ? 32'd3 : 32'd7)) begin
        n_bad++; $display("FAIL periodic_edge%0d got tl=%h tcon=%h", i, t, v);
      end
    end
    n_cmp++;
    if (irqout !== 1'b1 || irq_id !== 4'd0) begin
      n_bad++; $display("FAIL periodic_irq got %b/%h exp 1/0", irqout, irq_id);
    end
    PC31 = 1'b1;
    #1;
    n_cmp++;
    if (irqout !== 1'b0 || irq_id !== 4'd0) begin
      n_bad++; $display("FAIL periodic_pc31 got %b/%h exp 0/0", irqout, irq_id);
    end
    PC31 = 1'b0;
    addr = reg_addr(0, 0); rd = 1'b0;
    #1;
    n_cmp++;
    if (rdata !== 32'd0) begin n_bad++; $display("FAIL no_rd got %h exp 0", rdata); end
    rreg(32'h4000_0200, v);
    n_cmp++;
    if (v !== 32'd0) begin n_bad++; $display("FAIL miss_addr got %h exp 0", v); end
    wreg(0, 2, 32'd7);
    rreg(reg_addr(0, 2), v);
    n_cmp++;
    if (v !== 32'd3) begin n_bad++; $display("FAIL periodic_w1c got %h exp 3", v); end
    idle(2);
    rreg(reg_addr(0, 2), v);
    n_cmp++;
    if (v !== 32'd3) begin n_bad++; $display("FAIL periodic_early got %h exp 3", v); end
    idle(1);
    rreg(reg_addr(0, 2), v);
    rreg(reg_addr(0, 1), t);
    n_cmp++;
    if (v !== 32'd7 || t !== 32'hFFFF_FFFC) begin
      n_bad++; $display("FAIL periodic_rewrap got tcon=%h tl=%h exp 7/fffffffc", v, t);
    end
  endtask

  task automatic test_prescale();
    logic [31:0] t;
    do_reset();
    wreg(1, 3, 32'd2);
    wreg(1, 1, 32'd0);
    wreg(1, 2, 32'd1);
    for (int i = 1; i <= 6; i++) begin
      idle(1);
      rreg(reg_addr(1, 1), t);
      n_cmp++;
      if (t !== 32'(i / 3)) begin
        n_bad++; $display("FAIL prescale_edge%0d got %h exp %h", i, t, i / 3);
      end
    end
    idle(1);
    wreg(1, 2, 32'd1);
    idle(2);
    rreg(reg_addr(1, 1), t);
    n_cmp++;
    if (t !== 32'd2) begin n_bad++; $display("FAIL prescale_restart got %h exp 2", t); end
    idle(1);
    rreg(reg_addr(1, 1), t);
    n_cmp++;
    if (t !== 32'd3) begin n_bad++; $display("FAIL prescale_after got %h exp 3", t); end
  endtask

  task automatic test_oneshot();
    logic [31:0] v, t;
    do_reset();
    wreg(2, 0, 32'd0);
    wreg(2, 1, 32'hFFFF_FFFF);
    wreg(2, 2, 32'hB);
    idle(1);
    rreg(reg_addr(2, 2), v);
    rreg(reg_addr(2, 1), t);
    n_cmp++;
    if (v !== 32'hE || t !== 32'd0) begin
      n_bad++; $display("FAIL oneshot_fire got tcon=%h tl=%h exp e/0", v, t);
    end
    idle(3);
    rreg(reg_addr(2, 2), v);
    rreg(reg_addr(2, 1), t);
    n_cmp++;
    if (v !== 32'hE || t !== 32'd0) begin
      n_bad++; $display("FAIL oneshot_hold got tcon=%h tl=%h exp e/0", v, t);
    end
  endtask

  task automatic test_priority();
    logic [31:0] v, s;
    do_reset();
    wreg(3, 1, 32'hFFFF_FFFF);
    wreg(3, 2, 32'hB);
    wreg(1, 1, 32'hFFFF_FFFF);
    wreg(1, 2, 32'hB);
    idle(1);
    rreg(BASE + 32'hF0, s);
    rreg(BASE + 32'hF4, v);
    n_cmp++;
    if (irq_id !== 4'd1 || s !== 32'hA || v !== 32'd1 || irqout !== 1'b1) begin
      n_bad++; $display("FAIL prio_both got id=%h status=%h idreg=%h irq=%b exp 1/a/1/1", irq_id, s, v, irqout);
    end
    wreg(1, 2, 32'h6);
    n_cmp++;
    if (irq_id !== 4'd3 || irqout !== 1'b1) begin
      n_bad++; $display("FAIL prio_ch3 got id=%h irq=%b exp 3/1", irq_id, irqout);
    end
    wreg(3, 2, 32'h6);
    rreg(BASE + 32'hF0, s);
    n_cmp++;
    if (irq_id !== 4'hF || irqout !== 1'b0 || s !== 32'd0) begin
      n_bad++; $display("FAIL prio_none got id=%h irq=%b status=%h exp f/0/0", irq_id, irqout, s);
    end
  endtask

  task automatic test_collisions();
    logic [31:0] v, t;
    do_reset();
    wreg(0, 1, 32'hFFFF_FFFF);
    wreg(0, 2, 32'd3);
    wreg(0, 1, 32'd5);
    rreg(reg_addr(0, 1), t);
    rreg(reg_addr(0, 2), v);
    n_cmp++;
    if (t !== 32'd5 || v !== 32'd3) begin
      n_bad++; $display("FAIL coll_tl got tl=%h tcon=%h exp 5/3", t, v);
    end
    wreg(0, 1, 32'hFFFF_FFFF);
    wreg(0, 2, 32'd7);
    rreg(reg_addr(0, 1), t);
    rreg(reg_addr(0, 2), v);
    n_cmp++;
    if (t !== 32'd0 || v !== 32'd7) begin
      n_bad++; $display("FAIL coll_w1c got tl=%h tcon=%h exp 0/7", t, v);
    end
    wreg(0, 2, 32'hF);
    wreg(0, 1, 32'hFFFF_FFFF);
    wreg(0, 2, 32'hB);
    rreg(reg_addr(0, 2), v);
    n_cmp++;
    if (v !== 32'hF) begin n_bad++; $display("FAIL coll_en got tcon=%h exp f", v); end
    idle(3);
    @(negedge clk);
    #1;
    reset = 1'b0;
    m_reset();
    #1;
    rreg(reg_addr(0, 1), t);
    rreg(reg_addr(0, 2), v);
    n_cmp++;
    if (t !== 32'd0 || v !== 32'd0 || irqout !== 1'b0 || irq_id !== 4'hF) begin
      n_bad++; $display("FAIL coll_reset got tl=%h tcon=%h irq=%b id=%h", t, v, irqout, irq_id);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [31:0] v, d, tmp, a;
    int kind, c, r;
    do_reset();
    for (int it = 0; it < 400; it++) begin
      kind = $urandom_range(0, 9);
      c = $urandom_range(0, 4);
      r = $urandom_range(0, 3);
      tmp = $urandom;
      case (r)
        0: d = (tmp[0]) ? tmp : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
        1: d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        2: d = 32'($urandom_range(0, 15));
        default: d = {tmp[31:16], 16'($urandom_range(0, 3))};
      endcase
      if (kind < 4) tick_cycle(1'b1, reg_addr(c, r), d);
      else if (kind == 4) tick_cycle(1'b1, BASE + ((tmp[0]) ? 32'hF0 : 32'hF4), tmp);
      else tick_cycle(1'b0, 32'd0, 32'd0);
      PC31 = ($urandom_range(0, 3) == 0);
      c = $urandom_range(0, 3);
      for (int k = 0; k < 4; k++) begin
        a = reg_addr(c, k);
        rreg(a, v);
        n_cmp++;
        if (v !== m_read(a)) begin
          n_bad++; $display("FAIL rand_reg it%0d ch%0d r%0d got %h exp %h", it, c, k, v, m_read(a));
        end
      end
      rreg(BASE + 32'hF0, v);
      n_cmp++;
      if (v !== {28'd0, m_status()}) begin
        n_bad++; $display("FAIL rand_status it%0d got %h exp %h", it, v, m_status());
      end
      n_cmp++;
      if (irq_id !== m_id() || irqout !== ((|m_status()) & ~PC31)) begin
        n_bad++; $display("FAIL rand_irq it%0d got %b/%h exp %b/%h", it, irqout, irq_id, (|m_status()) & ~PC31, m_id());
      end
    end
    PC31 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_prescale();
    test_oneshot();
    test_priority();
    test_collisions();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
